// File: rtl/fgp_tx_scheduler.sv
// Sweeps NUM_PACKETS FGP packets per frame: start pulse, frame-RAM byte addressing, inter-packet gap, frame completion.
// Latency: pkt_start one cycle after eth_ready in WAIT_READY; rd_en/rd_addr combinational on readclk; backpressure via eth_ready/readclk.
module fgp_tx_scheduler #(
    parameter int NUM_PACKETS = 150,
    parameter int DATA_LEN    = 768,
    parameter int GAP_CYCLES  = 64,
    parameter int ADDR_W      = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_req,
    input  logic              continuous,
    input  logic              abort,
    input  logic              eth_ready,
    input  logic              readclk,
    input  logic              eth_done,
    output logic              pkt_start,
    output logic [7:0]        fgp_offset,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              in_done,
    output logic              busy,
    output logic              frame_done,
    output logic              err
);

    localparam int CNT_W = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0]  LAST_BYTE  = CNT_W'(DATA_LEN - 1);
    localparam logic [ADDR_W-1:0] DATA_LEN_A = ADDR_W'(DATA_LEN);
    localparam logic [8:0]        NUM_PKT_I  = 9'(NUM_PACKETS);
    localparam logic [GAP_W-1:0]  GAP_INIT   = GAP_W'(GAP_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_READY,
        S_START,
        S_STREAM,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [8:0]        pkt_idx_q, pkt_idx_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic              pending_q, pending_d;
    logic              pkt_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pkt_idx_q  <= '0;
            base_q     <= '0;
            byte_cnt_q <= '0;
            gap_cnt_q  <= '0;
            pending_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pkt_idx_q  <= pkt_idx_d;
            base_q     <= base_d;
            byte_cnt_q <= byte_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            pending_q  <= pending_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pkt_idx_d  = pkt_idx_q;
        base_d     = base_q;
        byte_cnt_d = byte_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        pending_d  = pending_q;
        pkt_start  = 1'b0;
        rd_en      = 1'b0;
        in_done    = 1'b0;
        frame_done = 1'b0;
        err        = 1'b0;
        pkt_done   = 1'b0;

        // Requests arriving mid-sweep collapse into a single pending sweep.
        if (frame_req && (state_q != S_IDLE)) begin
            pending_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (frame_req || pending_q) begin
                    state_d   = S_WAIT_READY;
                    pending_d = 1'b0;
                end
            end
            S_WAIT_READY: begin
                if (eth_ready) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                pkt_start  = 1'b1;
                byte_cnt_d = '0;
                state_d    = S_STREAM;
            end
            S_STREAM: begin
                rd_en = readclk;
                if (readclk) begin
                    byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    if (byte_cnt_q == LAST_BYTE) begin
                        state_d = S_WAIT_DONE;
                    end
                end
                if (eth_done) begin
                    err      = 1'b1;
                    pkt_done = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                in_done = 1'b1;
                if (eth_done) begin
                    pkt_done = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    if (pkt_idx_q == NUM_PKT_I) begin
                        frame_done = 1'b1;
                        pkt_idx_d  = '0;
                        base_d     = '0;
                        // A request landing on the final gap cycle is consumed by this restart.
                        if (continuous || pending_q || frame_req) begin
                            state_d   = S_WAIT_READY;
                            pending_d = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        state_d = S_WAIT_READY;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (pkt_done) begin
            state_d   = S_GAP;
            pkt_idx_d = pkt_idx_q + 9'd1;
            gap_cnt_d = GAP_INIT;
            // Base stays bounded by the last packet's offset; it is zeroed for the next sweep.
            if (pkt_idx_q == NUM_PKT_I - 9'd1) begin
                base_d = '0;
            end else begin
                base_d = base_q + DATA_LEN_A;
            end
        end

        if (abort) begin
            state_d    = S_IDLE;
            pkt_idx_d  = '0;
            base_d     = '0;
            byte_cnt_d = '0;
            pending_d  = 1'b0;
            pkt_start  = 1'b0;
            rd_en      = 1'b0;
            in_done    = 1'b0;
            frame_done = 1'b0;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign fgp_offset = pkt_idx_q[7:0];
    assign rd_addr    = base_q + ADDR_W'(byte_cnt_q);

endmodule

// File: tb/tb_fgp_tx_scheduler.sv
// Scoreboarded bench for fgp_tx_scheduler with a 3-packet, 4-byte, gap-2 configuration.
module tb_fgp_tx_scheduler;

    localparam int NP  = 3;
    localparam int DL  = 4;
    localparam int GAP = 2;
    localparam int AW  = 8;

    localparam logic [1:0] EV_START = 2'd0;
    localparam logic [1:0] EV_RD    = 2'd1;
    localparam logic [1:0] EV_ERR   = 2'd2;
    localparam logic [1:0] EV_FD    = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] val;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst_n, frame_req, continuous, abort, eth_ready, readclk, eth_done;
    logic          pkt_start, rd_en, in_done, busy, frame_done, err;
    logic [7:0]    fgp_offset;
    logic [AW-1:0] rd_addr;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    int  n_start  = 0;
    int  cyc      = 0;

    fgp_tx_scheduler #(
        .NUM_PACKETS(NP),
        .DATA_LEN   (DL),
        .GAP_CYCLES (GAP),
        .ADDR_W     (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_req  (frame_req),
        .continuous (continuous),
        .abort      (abort),
        .eth_ready  (eth_ready),
        .readclk    (readclk),
        .eth_done   (eth_done),
        .pkt_start  (pkt_start),
        .fgp_offset (fgp_offset),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .in_done    (in_done),
        .busy       (busy),
        .frame_done (frame_done),
        .err        (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] k, input int v);
        exp_q.push_back({k, 8'(v)});
    endtask

    task automatic mon_ev(input logic [1:0] k, input int v, input string name);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s: unexpected event with value %0d, expected none", name, v);
        end else begin
            e = exp_q.pop_front();
            check({name, " kind"}, int'(k), int'(e.kind));
            check({name, " value"}, v, int'(e.val));
        end
    endtask

    // Monitor: every output event is matched against the head of the expectation queue.
    always @(negedge clk) begin
        if (pkt_start) begin
            n_start++;
            mon_ev(EV_START, int'(fgp_offset), "pkt_start offset");
        end
        if (rd_en)      mon_ev(EV_RD, int'(rd_addr), "rd_addr");
        if (err)        mon_ev(EV_ERR, 0, "err");
        if (frame_done) mon_ev(EV_FD, 0, "frame_done");
    end

    task automatic check_outs_zero(input string tag);
        check({tag, " pkt_start"}, pkt_start, 0);
        check({tag, " rd_en"}, rd_en, 0);
        check({tag, " rd_addr"}, rd_addr, 0);
        check({tag, " in_done"}, in_done, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " frame_done"}, frame_done, 0);
        check({tag, " err"}, err, 0);
        check({tag, " fgp_offset"}, fgp_offset, 0);
    endtask

    task automatic wait_start(output int c);
        c = -1;
        for (int i = 0; i < 40; i++) begin
            if (pkt_start) begin
                c = cyc;
                break;
            end
            tick();
        end
        if (c < 0) begin
            n_checks++;
            $display("FAIL pkt_start timeout: no start within 40 cycles, expected one");
        end
    endtask

    task automatic pulse_req();
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
    endtask

    // One packet: expectations pushed first, then start/stream/eth_done driven.
    task automatic do_packet(input int off, input bit last, input bit mid_req, input bit early,
                             output int sc, output int dc);
        int base;
        int nb;
        base = off * DL;
        nb   = early ? 2 : DL;
        push(EV_START, off);
        for (int i = 0; i < nb; i++) push(EV_RD, base + i);
        if (early)     push(EV_ERR, 0);
        else if (last) push(EV_FD, 0);
        wait_start(sc);
        tick();
        for (int i = 0; i < nb; i++) begin
            readclk   = 1'b1;
            frame_req = mid_req && (i == 1);
            tick();
        end
        readclk   = 1'b0;
        frame_req = 1'b0;
        if (!early) begin
            check("in_done in WAIT_DONE", in_done, 1);
            check("fgp_offset held", fgp_offset, off);
        end
        eth_done = 1'b1;
        dc = cyc;
        tick();
        eth_done = 1'b0;
    endtask

    initial begin
        int sc, dc, prev_dc, seen, r;
        rst_n = 1'b1; frame_req = 1'b0; continuous = 1'b0; abort = 1'b0;
        eth_ready = 1'b1; readclk = 1'b0; eth_done = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_outs_zero("power-on reset");
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Reset asserted mid-STREAM with readclk high: outputs drop immediately.
        push(EV_START, 0); push(EV_RD, 0); push(EV_RD, 1);
        pulse_req();
        wait_start(sc);
        tick();
        readclk = 1'b1;
        tick(); tick();
        rst_n = 1'b0;
        #1 check_outs_zero("mid-stream reset");
        readclk = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Full sweep; gap from eth_done (cycle t) to pkt_start is GAP+1 gap cycles, WAIT_READY, START: t+5.
        pulse_req();
        prev_dc = 0;
        for (int p = 0; p < NP; p++) begin
            do_packet(p, p == NP - 1, 1'b0, 1'b0, sc, dc);
            if (p > 0) check("inter-packet gap", sc - prev_dc, GAP + 3);
            prev_dc = dc;
        end
        repeat (5) tick();
        check("idle after sweep", busy, 0);

        // eth_ready withheld: no start until it is raised, then START the cycle after.
        eth_ready = 1'b0;
        pulse_req();
        seen = 0;
        repeat (10) begin
            seen += int'(pkt_start);
            tick();
        end
        check("no start while not ready", seen, 0);
        check("busy in WAIT_READY", busy, 1);
        eth_ready = 1'b1;
        r = cyc;
        for (int p = 0; p < NP; p++) begin
            do_packet(p, p == NP - 1, 1'b0, 1'b0, sc, dc);
            if (p == 0) check("start after ready", sc - r, 1);
        end
        repeat (5) tick();
        check("idle after ready sweep", busy, 0);

        // Pending request during packet 1, then continuous restarts.
        pulse_req();
        for (int p = 0; p < NP; p++) do_packet(p, p == NP - 1, p == 1, 1'b0, sc, dc);
        prev_dc = dc;
        for (int s = 0; s < 2; s++) begin
            for (int p = 0; p < NP; p++) begin
                do_packet(p, p == NP - 1, 1'b0, 1'b0, sc, dc);
                if (p == 0) begin
                    check("restart without extra idle", sc - prev_dc, GAP + 3);
                    continuous = (s == 0);
                end
            end
            prev_dc = dc;
        end
        repeat (5) tick();
        check("idle after continuous off", busy, 0);

        // Abort in WAIT_DONE of packet 1, coinciding with a request that must be dropped.
        pulse_req();
        do_packet(0, 1'b0, 1'b0, 1'b0, sc, dc);
        push(EV_START, 1);
        for (int i = 0; i < DL; i++) push(EV_RD, DL + i);
        wait_start(sc);
        tick();
        readclk = 1'b1;
        repeat (DL) tick();
        readclk = 1'b0;
        check("in_done before abort", in_done, 1);
        abort = 1'b1;
        frame_req = 1'b1;
        #1 check("in_done forced by abort", in_done, 0);
        tick();
        abort = 1'b0;
        frame_req = 1'b0;
        check("idle after abort", busy, 0);
        check("rd_addr after abort", rd_addr, 0);
        check("offset after abort", fgp_offset, 0);
        repeat (3) tick();
        check("request dropped with abort", busy, 0);
        pulse_req();
        do_packet(0, 1'b0, 1'b0, 1'b1, sc, dc);
        do_packet(1, 1'b0, 1'b0, 1'b0, sc, dc);
        do_packet(2, 1'b1, 1'b0, 1'b0, sc, dc);
        repeat (5) tick();
        check("idle after err sweep", busy, 0);

        check("scoreboard drained", exp_q.size(), 0);
        check("total pkt_start pulses", n_start, 21);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
